instr_fetch_unit: RTL and testbench

Fetch stage of the 32-bit multicycle processor. It owns the program counter, drives the word address to the combinational instruction memory, and latches the returned word into the instruction register (IR) on request from the control FSM. When the control FSM commits the end of an instruction, the unit computes the next PC, covering sequential, taken-branch and jump cases. It halts once the PC runs past the loaded program.

---
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 tb/tb_instr_fetch_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, latches IR/NPC one cycle after FetchReq, computes next PC on UpdatePC.
// Turnaround IDLE->FETCH->HOLD->IDLE is 3 cycles; FetchReq/UpdatePC outside IDLE/HOLD are dropped, HALT is sticky.
module instr_fetch_unit #(
  parameter int unsigned         PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [PC_WIDTH-1:0] PROG_LENGTH = 26
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                FetchReq,
  input  logic [PC_WIDTH-1:0] Instruction,
  input  logic                UpdatePC,
  input  logic                BranchTaken,
  output logic [PC_WIDTH-1:0] PC,
  output logic [PC_WIDTH-1:0] IR,
  output logic [PC_WIDTH-1:0] NPC,
  output logic                IRValid,
  output logic                Halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [5:0] OP_J = 6'b000001;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] ir_q, ir_d;
  logic [PC_WIDTH-1:0] npc_q, npc_d;

  logic [5:0]          opcode;
  logic [PC_WIDTH-1:0] jmp_off;
  logic [PC_WIDTH-1:0] br_off;
  logic [PC_WIDTH-1:0] target_pc;

  assign opcode  = ir_q[PC_WIDTH-1 -: 6];
  assign jmp_off = {{(PC_WIDTH-26){ir_q[25]}}, ir_q[25:0]};
  assign br_off  = {{(PC_WIDTH-16){ir_q[15]}}, ir_q[15:0]};

  // Jump wins over branch; BranchTaken only matters for the 1000xx compare opcodes.
  always_comb begin
    target_pc = npc_q;
    if (opcode == OP_J) begin
      target_pc = npc_q + jmp_off;
    end else if ((opcode[5:2] == 4'b1000) && BranchTaken) begin
      target_pc = npc_q + br_off;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    npc_d   = npc_q;
    case (state_q)
      IDLE: begin
        if (FetchReq) begin
          state_d = (pc_q > PROG_LENGTH) ? HALT : FETCH;
        end
      end
      FETCH: begin
        ir_d    = Instruction;
        npc_d   = pc_q + PC_WIDTH'(1);
        state_d = HOLD;
      end
      HOLD: begin
        if (UpdatePC) begin
          pc_d    = target_pc;
          state_d = IDLE;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      npc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      npc_q   <= npc_d;
    end
  end

  assign PC      = pc_q;
  assign IR      = ir_q;
  assign NPC     = npc_q;
  assign IRValid = (state_q == HOLD);
  assign Halted  = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed program walk-through followed by random program/handshake traffic
// compared against a cycle-level reference model of the fetch protocol.
module tb_instr_fetch_unit;

  localparam logic [31:0] PROG_LEN = 32'd22;

  logic        Clk;
  logic        Rst_n;
  logic        FetchReq;
  logic [31:0] Instruction;
  logic        UpdatePC;
  logic        BranchTaken;
  logic [31:0] PC;
  logic [31:0] IR;
  logic [31:0] NPC;
  logic        IRValid;
  logic        Halted;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [64];

  // Reference model: phase 0 waiting for request, 1 reading memory, 2 instruction held, 3 halted.
  logic [31:0] m_pc, m_ir, m_npc;
  int          m_phase;

  instr_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'd0), .PROG_LENGTH(PROG_LEN)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .FetchReq(FetchReq), .Instruction(Instruction),
    .UpdatePC(UpdatePC), .BranchTaken(BranchTaken), .PC(PC), .IR(IR), .NPC(NPC),
    .IRValid(IRValid), .Halted(Halted)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always_comb begin
    if (PC < 32'd64) Instruction = mem[PC[5:0]];
    else             Instruction = 32'hDEAD_BEEF;
  end

  function automatic logic [31:0] ref_next_pc(logic [31:0] ir, logic [31:0] npc, logic bt);
    int unsigned op;
    logic signed [25:0] joff;
    logic signed [15:0] boff;
    op   = int'(ir[31:26]);
    joff = ir[25:0];
    boff = ir[15:0];
    if (op == 1)                        return npc + 32'(joff);
    else if (op >= 32 && op <= 35 && bt) return npc + 32'(boff);
    else                                return npc;
  endfunction

  function automatic logic [31:0] mem_at(logic [31:0] a);
    if (a < 32'd64) return mem[a[5:0]];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(string tag);
    check({tag, ".PC"}, PC, m_pc);
    check({tag, ".IR"}, IR, m_ir);
    check({tag, ".NPC"}, NPC, m_npc);
    check({tag, ".IRValid"}, {31'd0, IRValid}, {31'd0, m_phase == 2});
    check({tag, ".Halted"}, {31'd0, Halted}, {31'd0, m_phase == 3});
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_ir = 32'd0; m_npc = 32'd0; m_phase = 0;
  endtask

  task automatic model_edge(logic fr, logic up, logic bt);
    case (m_phase)
      0: if (fr) m_phase = (m_pc > PROG_LEN) ? 3 : 1;
      1: begin m_ir = mem_at(m_pc); m_npc = m_pc + 32'd1; m_phase = 2; end
      2: if (up) begin m_pc = ref_next_pc(m_ir, m_npc, bt); m_phase = 0; end
      default: ;
    endcase
  endtask

  task automatic step(string tag, logic fr, logic up, logic bt);
    FetchReq = fr; UpdatePC = up; BranchTaken = bt;
    @(posedge Clk);
    model_edge(fr, up, bt);
    #1;
    check_model(tag);
  endtask

  task automatic run_instr(string tag, logic bt);
    step({tag, ".req"}, 1'b1, 1'b0, 1'b0);
    step({tag, ".fetch"}, 1'b0, 1'b0, 1'b0);
    step({tag, ".upd"}, 1'b0, 1'b1, bt);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic async_reset(string tag);
    #2 Rst_n = 1'b0;
    model_reset();
    #1;
    check_model(tag);
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_word();
    int off;
    off = int'($urandom_range(0, 12)) - 6;
    case ($urandom_range(0, 4))
      0:       return {6'b000001, 26'(off)};
      1:       return {4'b1000, 2'($urandom_range(0, 3)), 10'($urandom), 16'(off)};
      2:       return {6'($urandom_range(2, 31)), 26'($urandom)};
      3:       return {6'($urandom_range(36, 63)), 26'($urandom)};
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    Rst_n = 1'b0; FetchReq = 1'b0; UpdatePC = 1'b0; BranchTaken = 1'b0;
    model_reset();
    #12;
    check_model("reset");
    @(negedge Clk);
    Rst_n = 1'b1;

    // Async reset while holding a branch word.
    mem[0] = 32'h8041_FFFD;
    step("rst_req", 1'b1, 1'b0, 1'b0);
    step("rst_fetch", 1'b0, 1'b0, 1'b0);
    check("rst_hold_ir", IR, 32'h8041_FFFD);
    async_reset("rst_hold");

    // Program: 0 misc, 1 J->12, 10 J->12, 12 BEQ -3, 13 J->18, 18 J +2, 21 ADDI, 22 NOOP.
    mem[0]  = 32'hE400_FFFF;
    mem[1]  = 32'h0400_000A;
    mem[10] = 32'h0400_0001;
    mem[12] = 32'h8041_FFFD;
    mem[13] = 32'h0400_0004;
    mem[18] = 32'h0400_0002;
    mem[21] = 32'hC800_0001;
    mem[22] = 32'h0000_0000;

    step("upd_in_idle", 1'b0, 1'b1, 1'b1);
    check("upd_in_idle_pc", PC, 32'd0);
    step("seq_req", 1'b1, 1'b0, 1'b0);
    step("seq_fetch", 1'b0, 1'b0, 1'b0);
    check("seq_ir", IR, 32'hE400_FFFF);
    check("seq_npc", NPC, 32'd1);
    step("seq_upd_with_req", 1'b1, 1'b1, 1'b0);
    check("seq_pc", PC, 32'd1);
    step("no_queued_fetch", 1'b0, 1'b0, 1'b0);
    check("no_queued_fetch_vld", {31'd0, IRValid}, 32'd0);

    run_instr("jmp_to_12", 1'b0);
    check("jmp_to_12_pc", PC, 32'd12);
    run_instr("beq_taken", 1'b1);
    check("beq_taken_pc", PC, 32'd10);
    run_instr("jmp_back", 1'b0);
    run_instr("beq_not_taken", 1'b0);
    check("beq_not_taken_pc", PC, 32'd13);
    run_instr("jmp_to_18", 1'b1);
    run_instr("jmp_bt_ignored", 1'b1);
    check("jmp_bt_ignored_pc", PC, 32'd21);
    run_instr("addi_bt", 1'b1);
    check("addi_bt_pc", PC, 32'd22);
    run_instr("noop", 1'b1);
    check("noop_pc", PC, 32'd23);

    step("halt_req", 1'b1, 1'b0, 1'b0);
    check("halt_flag", {31'd0, Halted}, 32'd1);
    check("halt_pc", PC, 32'd23);
    check("halt_ir", IR, 32'd0);
    for (int i = 0; i < 6; i++) begin
      step("halt_sticky", 1'($urandom), 1'($urandom), 1'($urandom));
    end
    async_reset("halt_reset");

    // Random programs and random handshake timing.
    for (int i = 0; i < 64; i++) mem[i] = rand_word();
    for (int i = 0; i < 600; i++) begin
      step("rand", 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 6), 1'($urandom));
      if ($urandom_range(0, 39) == 0) begin
        async_reset("rand_reset");
        for (int k = 0; k < 64; k++) mem[k] = rand_word();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
